// File: rtl/hs_stream_pkg.sv
// Shared widths and elaboration helpers for the ap_hs <-> AXI4-Stream adapters.
package hs_stream_pkg;

  localparam int HS_DATA_W = 64;
  localparam int PKT_CNT_W = 16;

  // Ceiling log2, evaluated at elaboration time for pointer and level widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hs_to_stream_adapter_if.sv
// Producer-side ap_hs port plus the outbound AXI4-Stream channel of the adapter.
interface hs_to_stream_adapter_if;
  import hs_stream_pkg::*;

  logic [HS_DATA_W-1:0] in_hs;
  logic                 in_hs_ap_vld;
  logic                 in_hs_ap_ack;
  logic [HS_DATA_W-1:0] outStream_tdata;
  logic                 outStream_tvalid;
  logic                 outStream_tready;
  logic                 outStream_tlast;

  // Adapter view: consumes ap_hs words, drives the stream.
  modport slave (
    input  in_hs,
    input  in_hs_ap_vld,
    output in_hs_ap_ack,
    output outStream_tdata,
    output outStream_tvalid,
    input  outStream_tready,
    output outStream_tlast
  );

  // Environment view: accelerator producer and downstream stream sink.
  modport master (
    output in_hs,
    output in_hs_ap_vld,
    input  in_hs_ap_ack,
    input  outStream_tdata,
    input  outStream_tvalid,
    output outStream_tready,
    input  outStream_tlast
  );

endinterface

// File: rtl/hs_to_stream_fifo.sv
// Synchronous DEPTH-entry FIFO with registered fill level; storage itself is never reset.
module hs_to_stream_fifo
  import hs_stream_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = HS_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  occupancy
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       occ_q;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (occ_q == FULL_LVL);
  assign empty   = (occ_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign rd_data   = mem[rd_ptr];
  assign occupancy = occ_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   occ_q <= occ_q + OCC_ONE;
        2'b01:   occ_q <= occ_q - OCC_ONE;
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/hs_to_stream_adapter.sv
// ap_hs producer port to AXI4-Stream master, buffered by a small FIFO, with TLAST from a word counter.
module hs_to_stream_adapter
  import hs_stream_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PKT_LEN = 0
) (
  input  logic                    aclk,
  input  logic                    areset,
  hs_to_stream_adapter_if.slave   hs,
  output logic [clog2(DEPTH):0]   occupancy
);

  localparam bit                   PKT_EN   = (PKT_LEN != 0);
  localparam logic [PKT_CNT_W-1:0] PKT_LAST = PKT_CNT_W'(PKT_EN ? PKT_LEN - 1 : 0);
  localparam logic [PKT_CNT_W-1:0] CNT_ONE  = PKT_CNT_W'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("hs_to_stream_adapter: DEPTH must be a power of two >= 2");
  end
  if (PKT_LEN < 0 || PKT_LEN > 65535) begin : g_bad_pkt_len
    $error("hs_to_stream_adapter: PKT_LEN must be in 0..65535");
  end

  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [HS_DATA_W-1:0] head_data;
  logic [PKT_CNT_W-1:0] pkt_cnt;
  logic                 tlast;

  // Ack and valid come only from the registered fill level, so neither
  // handshake input reaches the opposite side combinationally.
  assign hs.in_hs_ap_ack     = !full;
  assign hs.outStream_tvalid = !empty;
  assign hs.outStream_tdata  = head_data;
  assign hs.outStream_tlast  = tlast;

  assign push = hs.in_hs_ap_vld && !full;
  assign pop  = hs.outStream_tready && !empty;

  hs_to_stream_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (HS_DATA_W)
  ) u_fifo (
    .clk       (aclk),
    .rst       (areset),
    .push      (push),
    .wr_data   (hs.in_hs),
    .pop       (pop),
    .rd_data   (head_data),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy)
  );

  // Zero-length packets mean every word closes its own packet.
  assign tlast = PKT_EN ? (pkt_cnt == PKT_LAST) : 1'b1;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pkt_cnt <= '0;
    end else if (pop && PKT_EN) begin
      pkt_cnt <= tlast ? '0 : pkt_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hs_to_stream_adapter.sv
// Directed bench: two adapters (PKT_LEN=3 and PKT_LEN=0) share stimulus and a queue-based model.
module tb_hs_to_stream_adapter;
  import hs_stream_pkg::*;

  localparam int DEPTH = 4;
  localparam int PKT_A = 3;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  hs_to_stream_adapter_if ifa ();
  hs_to_stream_adapter_if ifb ();
  logic [2:0] occ_a;
  logic [2:0] occ_b;

  hs_to_stream_adapter #(.DEPTH(DEPTH), .PKT_LEN(PKT_A)) dut_a (
    .aclk(aclk), .areset(areset), .hs(ifa), .occupancy(occ_a));
  hs_to_stream_adapter #(.DEPTH(DEPTH), .PKT_LEN(0)) dut_b (
    .aclk(aclk), .areset(areset), .hs(ifb), .occupancy(occ_b));

  int checks = 0;
  int errors = 0;

  logic [63:0] mq[$];
  int          pop_total = 0;
  bit          m_push;
  bit          m_pop;

  typedef struct {
    logic [63:0] d;
    logic        la;
    logic        lb;
  } pop_t;
  pop_t plog[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit vld, input logic [63:0] d, input bit rdy);
    ifa.in_hs = d;  ifa.in_hs_ap_vld = vld;  ifa.outStream_tready = rdy;
    ifb.in_hs = d;  ifb.in_hs_ap_vld = vld;  ifb.outStream_tready = rdy;
  endtask

  task automatic reset_dut();
    drive(1'b0, 64'h0, 1'b0);
    @(negedge aclk);
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
  endtask

  // Reference model: FIFO as a queue, TLAST from the count of pops since reset.
  initial forever begin
    @(posedge aclk or posedge areset);
    if (areset) begin
      mq.delete();
      pop_total = 0;
    end else begin
      m_push = ifa.in_hs_ap_vld && (mq.size() < DEPTH);
      m_pop  = ifa.outStream_tready && (mq.size() > 0);
      if (m_pop) begin
        void'(mq.pop_front());
        pop_total++;
      end
      if (m_push) mq.push_back(ifa.in_hs);
    end
  end

  initial forever begin
    @(posedge aclk);
    if (!areset && ifa.outStream_tvalid && ifa.outStream_tready)
      plog.push_back('{ifa.outStream_tdata, ifa.outStream_tlast, ifb.outStream_tlast});
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge aclk);
    chk("m_occ_a", 64'(occ_a), 64'(mq.size()));
    chk("m_occ_b", 64'(occ_b), 64'(mq.size()));
    chk("m_ack_a", 64'(ifa.in_hs_ap_ack), 64'(mq.size() != DEPTH));
    chk("m_ack_b", 64'(ifb.in_hs_ap_ack), 64'(mq.size() != DEPTH));
    chk("m_tvalid_a", 64'(ifa.outStream_tvalid), 64'(mq.size() != 0));
    chk("m_tvalid_b", 64'(ifb.outStream_tvalid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("m_tdata_a", ifa.outStream_tdata, mq[0]);
      chk("m_tdata_b", ifb.outStream_tdata, mq[0]);
      chk("m_tlast_a", 64'(ifa.outStream_tlast), 64'((pop_total % PKT_A) == PKT_A - 1));
      chk("m_tlast_b", 64'(ifb.outStream_tlast), 64'h1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish t=%0t", $time);
    $fatal(1);
  end

  logic [7:0] stall_pat;
  int         idx;
  int         cyc;
  int         bad;
  bit         ack_s;

  initial begin
    drive(1'b0, 64'h0, 1'b0);
    stall_pat = 8'b1011_0010;
    repeat (3) @(negedge aclk);
    chk("rst_ack", 64'(ifa.in_hs_ap_ack), 64'h1);
    chk("rst_tvalid", 64'(ifa.outStream_tvalid), 64'h0);
    chk("rst_occ", 64'(occ_a), 64'h0);
    areset = 1'b0;

    // Fill with 1..4 against a stalled sink; the fifth offer (5) waits.
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("fill_ack%0d", c), 64'(ifa.in_hs_ap_ack), 64'(c < 4));
      drive(1'b1, (c < 4) ? 64'(c + 1) : 64'h5, 1'b0);
      @(negedge aclk);
    end
    chk("full_occ", 64'(occ_a), 64'h4);
    chk("full_tvalid", 64'(ifa.outStream_tvalid), 64'h1);
    chk("full_tdata", ifa.outStream_tdata, 64'h1);

    // One-cycle ready pulse from full; 5 then enters through the wrapped pointer.
    plog.delete();
    drive(1'b1, 64'h5, 1'b1);
    @(negedge aclk);
    chk("pulse_occ", 64'(occ_a), 64'h3);
    chk("pulse_ack", 64'(ifa.in_hs_ap_ack), 64'h1);
    chk("pulse_tdata", ifa.outStream_tdata, 64'h2);
    drive(1'b1, 64'h5, 1'b0);
    @(negedge aclk);
    chk("wrap_occ", 64'(occ_a), 64'h4);
    chk("wrap_ack", 64'(ifa.in_hs_ap_ack), 64'h0);
    drive(1'b0, 64'h0, 1'b1);
    repeat (5) @(negedge aclk);
    drive(1'b0, 64'h0, 1'b0);
    chk("drain_occ", 64'(occ_a), 64'h0);
    chk("drain_tvalid", 64'(ifa.outStream_tvalid), 64'h0);
    chk("drain_cnt", 64'(plog.size()), 64'h5);
    bad = 0;
    foreach (plog[i]) if (plog[i].d !== 64'(i + 1)) bad++;
    chk("drain_order", 64'(bad), 64'h0);

    // Continuous flow: one word per cycle, level pinned at 1.
    plog.delete();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 64'(i), 1'b1);
      @(negedge aclk);
      if (occ_a !== 3'd1) bad++;
    end
    drive(1'b0, 64'h0, 1'b1);
    repeat (2) @(negedge aclk);
    drive(1'b0, 64'h0, 1'b0);
    chk("stream_occ1", 64'(bad), 64'h0);
    chk("stream_cnt", 64'(plog.size()), 64'd100);
    bad = 0;
    foreach (plog[i]) if (plog[i].d !== 64'(i)) bad++;
    chk("stream_order", 64'(bad), 64'h0);

    // Packets of three with ready stalls: TLAST on words 3 and 6 only.
    reset_dut();
    plog.delete();
    idx = 1;
    cyc = 0;
    while (plog.size() < 7 && cyc < 200) begin
      ack_s = ifa.in_hs_ap_ack;
      drive(idx <= 7, 64'(idx), stall_pat[cyc % 8]);
      @(negedge aclk);
      if (idx <= 7 && ack_s) idx++;
      cyc++;
    end
    drive(1'b0, 64'h0, 1'b0);
    chk("pkt_cnt", 64'(plog.size()), 64'h7);
    foreach (plog[i]) begin
      chk($sformatf("pkt_data%0d", i + 1), plog[i].d, 64'(i + 1));
      chk($sformatf("pkt_tlast_a%0d", i + 1), 64'(plog[i].la), 64'(i == 2 || i == 5));
      chk($sformatf("pkt_tlast_b%0d", i + 1), 64'(plog[i].lb), 64'h1);
    end

    // Asynchronous reset with three words parked behind a stall.
    for (int d = 'h11; d <= 'h13; d++) begin
      drive(1'b1, 64'(d), 1'b0);
      @(negedge aclk);
    end
    drive(1'b0, 64'h0, 1'b0);
    chk("pre_rst_occ", 64'(occ_a), 64'h3);
    @(posedge aclk);
    #2 areset = 1'b1;
    #1;
    chk("arst_tvalid_a", 64'(ifa.outStream_tvalid), 64'h0);
    chk("arst_tvalid_b", 64'(ifb.outStream_tvalid), 64'h0);
    chk("arst_ack", 64'(ifa.in_hs_ap_ack), 64'h1);
    chk("arst_occ", 64'(occ_a), 64'h0);
    repeat (2) @(negedge aclk);
    areset = 1'b0;

    plog.delete();
    drive(1'b1, 64'hAA, 1'b1);
    @(negedge aclk);
    chk("post_rst_tdata", ifa.outStream_tdata, 64'hAA);
    chk("post_rst_tvalid", 64'(ifa.outStream_tvalid), 64'h1);
    chk("post_rst_occ", 64'(occ_a), 64'h1);
    drive(1'b1, 64'hAB, 1'b1);
    @(negedge aclk);
    drive(1'b1, 64'hAC, 1'b1);
    @(negedge aclk);
    drive(1'b0, 64'h0, 1'b1);
    repeat (3) @(negedge aclk);
    drive(1'b0, 64'h0, 1'b0);
    chk("post_rst_cnt", 64'(plog.size()), 64'h3);
    foreach (plog[i]) begin
      chk($sformatf("post_rst_data%0d", i), plog[i].d, 64'hAA + 64'(i));
      chk($sformatf("post_rst_tlast%0d", i), 64'(plog[i].la), 64'(i == 2));
    end

    @(negedge aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
